param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data bits per entry, legal range 1..256.
REQ-002 Parameter DEPTH, default 8: number of entries, power of two, legal range 2..1024.
REQ-003 Parameter AF_LEVEL, default DEPTH-2: almost_full asserts when data_count >= AF_LEVEL.
REQ-004 Parameter AE_LEVEL, default 2: almost_empty asserts when data_count <= AE_LEVEL.
REQ-005 Port clk, input, 1: single clock, rising edge.
REQ-006 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 Port wr_en, input, 1: write request.
REQ-008 Port rd_en, input, 1: read request.
REQ-009 Port d_in, input, DATA_WIDTH: write data.
REQ-010 Port d_out, output, DATA_WIDTH: registered read data.
REQ-011 Port full and port empty, outputs, 1 each: combinational from data_count.
REQ-012 Ports wr_ack, wr_err, rd_ack, rd_err, outputs, 1 each: registered status of the previous cycle's request.
REQ-013 Ports almost_full and almost_empty, outputs, 1 each: watermark flags.
REQ-014 Port data_count, output, $clog2(DEPTH)+1 bits: current occupancy, 0..DEPTH.

Function
REQ-015 A write is accepted when wr_en=1 and either not full, or full with rd_en=1 on the same cycle.
REQ-016 A read is accepted when rd_en=1 and not empty; a read on empty is always rejected, even if wr_en=1 on the same cycle.
REQ-017 FSM states: INIT, NO_OP, WRITE, READ, RD_WR, WR_ERROR, RD_ERROR, RD_WR_ERROR; the next state is decoded each cycle from wr_en, rd_en and data_count.
REQ-018 A rejected request with no accepted request on the same cycle enters WR_ERROR or RD_ERROR.
REQ-019 One request accepted and the other rejected enters RD_WR_ERROR.
REQ-020 The state holds one cycle; ack and err outputs are decoded from the state only.
REQ-021 data_count changes by +1 on an accepted write only, -1 on an accepted read only, and 0 on both or neither.
REQ-022 Head and tail are $clog2(DEPTH)-bit pointers that wrap from DEPTH-1 to 0 with no special handling.
REQ-023 d_out is loaded with mem[head] on the edge that accepts a read, giving one-cycle latency; otherwise d_out is loaded with 0.
REQ-024 Simultaneous read and write when full: the read returns the old head entry and the write lands at the same slot; data_count stays DEPTH.
REQ-025 wr_err=1 with no state change when a write is attempted on full without a read.
REQ-026 rd_err=1 with d_out=0 when a read is attempted on empty.

Reset
REQ-027 With reset_n=0, state=INIT, head=tail=0, data_count=0, d_out=0 and all ack/err outputs=0, asynchronously; memory contents are not reset.
REQ-028 Reset asserted mid-operation discards all stored entries; the first edge after release behaves as from empty.

Configuration
REQ-029 Macro PARAM_FIFO_WATERMARK_EN defined: almost_full and almost_empty follow REQ-003 and REQ-004, and are combinational from data_count.
REQ-030 Macro undefined: almost_full and almost_empty are tied to 0, and AF_LEVEL and AE_LEVEL have no effect.

Structure
REQ-031 Package param_fifo_pkg holds the 3-bit state encoding constants and the helper function for the count width.
REQ-032 Storage is a single sub-module param_fifo_mem: synchronous write and asynchronous read, parameterised by DATA_WIDTH and DEPTH.

Verification
REQ-033 Reset, then DEPTH=8 writes of 1..8 -> wr_ack each cycle, full=1, data_count=8.
REQ-034 Ninth write without read -> wr_err=1 for one cycle, data_count stays 8.
REQ-035 Eight reads -> d_out 1..8 in order, each one cycle after its request; then empty=1.
REQ-036 rd_en and wr_en together on empty with d_in=0xA5 -> rd_err=1, data_count=1, and the next read returns 0xA5.
REQ-037 rd_en and wr_en together on full -> rd_ack=wr_ack=1, data_count=8, oldest entry out, and order preserved across the pointer wrap.
REQ-038 With PARAM_FIFO_WATERMARK_EN defined, fill to 6 -> almost_full=1; drain to 2 -> almost_empty=1; pulse reset_n low mid-fill -> all outputs 0 immediately.

Source files
------------

// File: rtl/param_fifo_pkg.sv
// ============================================================
// param_fifo_pkg : FSM state encodings and count-width helper.
// Rev 1.0
// ============================================================
`default_nettype none

package param_fifo_pkg;

  localparam logic [2:0] ST_INIT        = 3'd0;
  localparam logic [2:0] ST_NO_OP       = 3'd1;
  localparam logic [2:0] ST_WRITE       = 3'd2;
  localparam logic [2:0] ST_READ        = 3'd3;
  localparam logic [2:0] ST_RD_WR       = 3'd4;
  localparam logic [2:0] ST_WR_ERROR    = 3'd5;
  localparam logic [2:0] ST_RD_ERROR    = 3'd6;
  localparam logic [2:0] ST_RD_WR_ERROR = 3'd7;

  // One extra bit so the count can represent DEPTH itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/param_fifo_mem.sv
// ============================================================
// param_fifo_mem : FIFO storage, synchronous write, async read.
// Rev 1.0
// ============================================================
`default_nettype none

module param_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/param_fifo.sv
// ============================================================
// param_fifo : single-clock FIFO with request/status FSM;
// watermark flags enabled by PARAM_FIFO_WATERMARK_EN. Rev 1.0
// ============================================================
`default_nettype none

module param_fifo
  import param_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        wr_en,
  input  logic                        rd_en,
  input  logic [DATA_WIDTH-1:0]       d_in,
  output logic [DATA_WIDTH-1:0]       d_out,
  output logic                        full,
  output logic                        empty,
  output logic                        wr_ack,
  output logic                        wr_err,
  output logic                        rd_ack,
  output logic                        rd_err,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [cnt_width(DEPTH)-1:0] data_count
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [ADDR_W-1:0]     head;
  logic [ADDR_W-1:0]     tail;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  wr_acc;
  logic                  rd_acc;

  assign full  = (data_count == FULL_CNT);
  assign empty = (data_count == '0);

  // A full FIFO still takes a write when the same cycle's read frees a slot.
  assign wr_acc = wr_en && (!full || rd_en);
  assign rd_acc = rd_en && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = ST_NO_OP;
    if (wr_acc && rd_acc) begin
      state_nxt = ST_RD_WR;
    end else if (wr_acc) begin
      state_nxt = rd_en ? ST_RD_WR_ERROR : ST_WRITE;
    end else if (rd_acc) begin
      state_nxt = wr_en ? ST_RD_WR_ERROR : ST_READ;
    end else if (wr_en) begin
      state_nxt = ST_WR_ERROR;
    end else if (rd_en) begin
      state_nxt = ST_RD_ERROR;
    end
  end

  // Only the read side can be rejected in RD_WR_ERROR (write on empty is always taken).
  always_comb begin
    wr_ack = 1'b0;
    wr_err = 1'b0;
    rd_ack = 1'b0;
    rd_err = 1'b0;
    case (state)
      ST_WRITE:       wr_ack = 1'b1;
      ST_READ:        rd_ack = 1'b1;
      ST_RD_WR: begin
        wr_ack = 1'b1;
        rd_ack = 1'b1;
      end
      ST_WR_ERROR:    wr_err = 1'b1;
      ST_RD_ERROR:    rd_err = 1'b1;
      ST_RD_WR_ERROR: begin
        wr_ack = 1'b1;
        rd_err = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head       <= '0;
      tail       <= '0;
      data_count <= '0;
      d_out      <= '0;
    end else begin
      d_out <= rd_acc ? mem_rd_data : '0;
      if (wr_acc) begin
        tail <= tail + 1'b1;
      end
      if (rd_acc) begin
        head <= head + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   data_count <= data_count + 1'b1;
        2'b01:   data_count <= data_count - 1'b1;
        default: data_count <= data_count;
      endcase
    end
  end

  param_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (tail),
    .wr_data (d_in),
    .rd_addr (head),
    .rd_data (mem_rd_data)
  );

`ifdef PARAM_FIFO_WATERMARK_EN
  localparam logic [CNT_W-1:0] AF_CNT = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT = CNT_W'(AE_LEVEL);

  assign almost_full  = (data_count >= AF_CNT);
  assign almost_empty = (data_count <= AE_CNT);
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_param_fifo.sv
// ============================================================
// tb_param_fifo : scoreboard bench for param_fifo (DEPTH=8, 32b).
// Rev 1.0
// ============================================================
`default_nettype none

module tb_param_fifo;

  localparam int DW = 32;
  localparam int DP = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] d_in = '0;
  logic [DW-1:0] d_out;
  logic          full, empty, wr_ack, wr_err, rd_ack, rd_err;
  logic          almost_full, almost_empty;
  logic [CW-1:0] data_count;

  logic [DW-1:0] sb_q[$];
  int            model_cnt = 0;
  logic          exp_wa, exp_ra;
  logic [3:0]    exp_stat;
  logic [DW-1:0] exp_dout;
  int            n_pass = 0;
  int            n_total = 0;

  always #5 clk = ~clk;

  param_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DP),
    .AF_LEVEL   (6),
    .AE_LEVEL   (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .d_in         (d_in),
    .d_out        (d_out),
    .full         (full),
    .empty        (empty),
    .wr_ack       (wr_ack),
    .wr_err       (wr_err),
    .rd_ack       (rd_ack),
    .rd_err       (rd_err),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .data_count   (data_count)
  );

  // Predict acceptance from the bench's own occupancy, update the scoreboard, then clock once.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    exp_wa   = w && (model_cnt < DP || r);
    exp_ra   = r && (model_cnt > 0);
    exp_stat = {exp_wa, w && !exp_wa, exp_ra, r && !exp_ra};
    exp_dout = '0;
    if (exp_ra) exp_dout = sb_q.pop_front();
    if (exp_wa) sb_q.push_back(d);
    model_cnt = model_cnt + (exp_wa ? 1 : 0) - (exp_ra ? 1 : 0);
    wr_en = w;
    rd_en = r;
    d_in  = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    d_in  = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({wr_ack, wr_err, rd_ack, rd_err} !== 4'b0000)
      $display("FAIL reset_stat: got %b want 0000", {wr_ack, wr_err, rd_ack, rd_err});
    else n_pass++;
    n_total++;
    if (d_out !== '0) $display("FAIL reset_dout: got %h want 0", d_out); else n_pass++;
    n_total++;
    if (data_count !== '0) $display("FAIL reset_count: got %0d want 0", data_count); else n_pass++;
    n_total++;
    if ({full, empty} !== 2'b01) $display("FAIL reset_flags: got full/empty %b want 01", {full, empty});
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    sb_q.delete();
    model_cnt = 0;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DP; i++) begin
      step(1'b1, 1'b0, DW'(i));
      n_total++;
      if ({wr_ack, wr_err, rd_ack, rd_err} !== exp_stat)
        $display("FAIL fill_stat[%0d]: got %b want %b", i, {wr_ack, wr_err, rd_ack, rd_err}, exp_stat);
      else n_pass++;
      n_total++;
      if (data_count !== CW'(model_cnt))
        $display("FAIL fill_count[%0d]: got %0d want %0d", i, data_count, model_cnt);
      else n_pass++;
    end
    n_total++;
    if ({full, empty} !== 2'b10) $display("FAIL fill_full: got full/empty %b want 10", {full, empty});
    else n_pass++;
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b0, 32'hDEAD_BEEF);
    n_total++;
    if ({wr_ack, wr_err, rd_ack, rd_err} !== 4'b0100)
      $display("FAIL ovf_stat: got %b want 0100", {wr_ack, wr_err, rd_ack, rd_err});
    else n_pass++;
    n_total++;
    if (data_count !== CW'(DP)) $display("FAIL ovf_count: got %0d want %0d", data_count, DP); else n_pass++;
    step(1'b0, 1'b0, '0);
    n_total++;
    if ({wr_ack, wr_err, rd_ack, rd_err} !== 4'b0000)
      $display("FAIL ovf_clear: got %b want 0000", {wr_ack, wr_err, rd_ack, rd_err});
    else n_pass++;
  endtask

  task automatic test_drain();
    for (int i = 0; i < DP; i++) begin
      step(1'b0, 1'b1, '0);
      n_total++;
      if (d_out !== exp_dout) $display("FAIL drain_dout[%0d]: got %h want %h", i, d_out, exp_dout);
      else n_pass++;
      n_total++;
      if ({wr_ack, wr_err, rd_ack, rd_err} !== exp_stat)
        $display("FAIL drain_stat[%0d]: got %b want %b", i, {wr_ack, wr_err, rd_ack, rd_err}, exp_stat);
      else n_pass++;
    end
    n_total++;
    if ({full, empty, data_count} !== {2'b01, CW'(0)})
      $display("FAIL drain_empty: got full/empty/count %b/%0d want 01/0", {full, empty}, data_count);
    else n_pass++;
    step(1'b0, 1'b1, '0);
    n_total++;
    if ({rd_err, d_out} !== {1'b1, DW'(0)})
      $display("FAIL rd_on_empty: got rd_err=%b d_out=%h want 1/0", rd_err, d_out);
    else n_pass++;
  endtask

  task automatic test_empty_rdwr();
    step(1'b1, 1'b1, 32'h0000_00A5);
    n_total++;
    if ({wr_ack, wr_err, rd_ack, rd_err} !== 4'b1001)
      $display("FAIL empty_rdwr_stat: got %b want 1001", {wr_ack, wr_err, rd_ack, rd_err});
    else n_pass++;
    n_total++;
    if ({data_count, d_out} !== {CW'(1), DW'(0)})
      $display("FAIL empty_rdwr_cnt: got count=%0d d_out=%h want 1/0", data_count, d_out);
    else n_pass++;
    step(1'b0, 1'b1, '0);
    n_total++;
    if (d_out !== exp_dout || d_out !== 32'h0000_00A5)
      $display("FAIL empty_rdwr_read: got %h want %h", d_out, exp_dout);
    else n_pass++;
  endtask

  task automatic test_full_rdwr();
    for (int i = 0; i < DP; i++) step(1'b1, 1'b0, 32'h100 + DW'(i));
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 32'h200 + DW'(i));
      n_total++;
      if ({wr_ack, wr_err, rd_ack, rd_err} !== 4'b1010)
        $display("FAIL full_rdwr_stat[%0d]: got %b want 1010", i, {wr_ack, wr_err, rd_ack, rd_err});
      else n_pass++;
      n_total++;
      if (data_count !== CW'(DP)) $display("FAIL full_rdwr_count[%0d]: got %0d want %0d", i, data_count, DP);
      else n_pass++;
      n_total++;
      if (d_out !== exp_dout) $display("FAIL full_rdwr_dout[%0d]: got %h want %h", i, d_out, exp_dout);
      else n_pass++;
    end
    for (int i = 0; i < DP; i++) begin
      step(1'b0, 1'b1, '0);
      n_total++;
      if (d_out !== exp_dout) $display("FAIL wrap_order[%0d]: got %h want %h", i, d_out, exp_dout);
      else n_pass++;
    end
  endtask

  task automatic test_watermark();
    logic exp_af, exp_ae;
    for (int i = 0; i < 10; i++) begin
      if (i < 6) step(1'b1, 1'b0, 32'h300 + DW'(i));
      else step(1'b0, 1'b1, '0);
`ifdef PARAM_FIFO_WATERMARK_EN
      exp_af = (model_cnt >= 6);
      exp_ae = (model_cnt <= 2);
`else
      exp_af = 1'b0;
      exp_ae = 1'b0;
`endif
      n_total++;
      if ({almost_full, almost_empty} !== {exp_af, exp_ae})
        $display("FAIL watermark[%0d]: got af/ae %b want %b (count %0d)", i,
                 {almost_full, almost_empty}, {exp_af, exp_ae}, model_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 32'h400);
    #2;
    reset_n = 1'b0;
    #1;
    sb_q.delete();
    model_cnt = 0;
    n_total++;
    if ({wr_ack, wr_err, rd_ack, rd_err, data_count, d_out} !== '0)
      $display("FAIL mid_reset_async: got stat=%b count=%0d d_out=%h want all 0",
               {wr_ack, wr_err, rd_ack, rd_err}, data_count, d_out);
    else n_pass++;
    n_total++;
    if ({full, empty, almost_full} !== 3'b010)
      $display("FAIL mid_reset_flags: got full/empty/af %b want 010", {full, empty, almost_full});
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 1'b1, '0);
    n_total++;
    if ({rd_err, rd_ack, d_out} !== {2'b10, DW'(0)})
      $display("FAIL post_reset_read: got rd_err=%b rd_ack=%b d_out=%h want 1/0/0", rd_err, rd_ack, d_out);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_empty_rdwr();
    test_full_rdwr();
    test_watermark();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
